// File: rtl/byteswap_pkg.sv
// byteswap_pkg: shared state type, default bus geometry and the group-reversal helper
// used by the byteswap stage for both data bytes and byte enables.
package byteswap_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int LP_DW_BYTES = 512 / 8;
    localparam int LP_BYTES_PER_WORD = 32 / 8;
    localparam int LP_MAX_WORD_BITS = 512;
    localparam int LP_IW = $clog2(LP_MAX_WORD_BITS);
    // Reverses the order of n groups of b bits held in the low n*b bits of w.
    function automatic logic [LP_MAX_WORD_BITS-1:0] bswap_word(
        input logic [LP_MAX_WORD_BITS-1:0] w,
        input int n,
        input int b
    );
        logic [LP_MAX_WORD_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < n * b; i++) r[LP_IW'(i)] = w[LP_IW'((n - 1 - i / b) * b + i % b)];
        return r;
    endfunction
endpackage

// File: rtl/byteswap_skid.sv
// byteswap_skid: 2-entry registered AXIS buffer; input ready is registered and only
// depends on the occupancy it will have next cycle, never on ready_i combinationally.
module byteswap_skid
    import byteswap_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         ap_clk,
    input  logic         areset,
    input  logic         en_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic [W-1:0] mem_q [2];
    logic wr_q, rd_q, ready_q, push, pop;
    logic [1:0] occ_q, occ_d;

    assign push = valid_i & ready_q;
    assign pop = valid_o & ready_i;
    assign occ_d = occ_q + 2'(push) - 2'(pop);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            mem_q <= '{default: '0};
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            occ_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= data_i;
            wr_q <= wr_q ^ push;
            rd_q <= rd_q ^ pop;
            occ_q <= occ_d;
            ready_q <= en_i && occ_d != 2'd2;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = occ_q != 2'd0;
    assign data_o = mem_q[rd_q];
endmodule

// File: rtl/byteswap_swapper.sv
// byteswap_swapper: AXIS stage reversing bytes within each word, regenerating tlast and pulsing done.
// Define BYTESWAP_TLAST_CHECK_EN to flag input tlast that disagrees with the programmed length.
module byteswap_swapper
    import byteswap_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = LP_DW_BYTES * 8,
    parameter int C_WORD_BIT_WIDTH   = LP_BYTES_PER_WORD * 8,
    parameter int C_BYTE_BIT_WIDTH   = 8,
    parameter int C_XFER_SIZE_WIDTH  = 32
) (
    input  logic                            ap_clk,
    input  logic                            areset,
    input  logic                            ctrl_start,
    input  logic [C_XFER_SIZE_WIDTH-1:0]    ctrl_xfer_bytes,
    output logic                            ctrl_done,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                            s_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast,
    output logic                            err_tlast
);
    localparam int LP_DWB = C_AXIS_TDATA_WIDTH / 8;
    localparam int LP_N = C_WORD_BIT_WIDTH / C_BYTE_BIT_WIDTH;
    localparam int LP_NW = C_AXIS_TDATA_WIDTH / C_WORD_BIT_WIDTH;
    localparam int LP_SW = C_AXIS_TDATA_WIDTH + LP_DWB + 1;
    localparam int LP_XW = C_XFER_SIZE_WIDTH;

    if (C_AXIS_TDATA_WIDTH % C_WORD_BIT_WIDTH != 0 || C_WORD_BIT_WIDTH % C_BYTE_BIT_WIDTH != 0 ||
        C_WORD_BIT_WIDTH > LP_MAX_WORD_BITS) begin : g_bad_cfg
        $error("byteswap_swapper: TDATA must be a multiple of WORD and WORD a multiple of BYTE");
    end

    state_t state_q, state_d;
    logic [LP_XW-1:0] cnt_q, cnt_d, beats_q, beats_d, beats_calc;
    logic done_q, done_d, s_hs, last_in;
    logic [C_AXIS_TDATA_WIDTH-1:0] swap_data;
    logic [LP_DWB-1:0] swap_keep;

    for (genvar w = 0; w < LP_NW; w++) begin : g_word
        assign swap_data[w*C_WORD_BIT_WIDTH +: C_WORD_BIT_WIDTH] = C_WORD_BIT_WIDTH'(bswap_word(
            LP_MAX_WORD_BITS'(s_axis_tdata[w*C_WORD_BIT_WIDTH +: C_WORD_BIT_WIDTH]), LP_N, C_BYTE_BIT_WIDTH));
        assign swap_keep[w*LP_N +: LP_N] = LP_N'(bswap_word(
            LP_MAX_WORD_BITS'(s_axis_tkeep[w*LP_N +: LP_N]), LP_N, 1));
    end

    assign beats_calc = LP_XW'(({1'b0, ctrl_xfer_bytes} + (LP_XW+1)'(LP_DWB - 1)) / (LP_XW+1)'(LP_DWB));
    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign last_in = cnt_q == beats_q - LP_XW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        beats_d = beats_q;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: if (ctrl_start) begin
                beats_d = beats_calc;
                cnt_d = '0;
                done_d = beats_calc == '0;
                state_d = beats_calc == '0 ? IDLE : RUN;
            end
            RUN: if (s_hs) begin
                cnt_d = cnt_q + LP_XW'(1);
                state_d = last_in ? DRAIN : RUN;
            end
            DRAIN: state_d = m_axis_tvalid ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            beats_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            beats_q <= beats_d;
            done_q <= done_d;
        end
    end

    // Zero-length starts finish from done_q; real transfers finish once DRAIN sees the buffer empty.
    assign ctrl_done = done_q | (state_q == DRAIN && !m_axis_tvalid);

    byteswap_skid #(.W(LP_SW)) u_skid (
        .ap_clk  (ap_clk),
        .areset  (areset),
        .en_i    (state_d == RUN),
        .valid_i (s_axis_tvalid),
        .ready_o (s_axis_tready),
        .data_i  ({swap_data, swap_keep, last_in}),
        .valid_o (m_axis_tvalid),
        .ready_i (m_axis_tready),
        .data_o  ({m_axis_tdata, m_axis_tkeep, m_axis_tlast})
    );

`ifdef BYTESWAP_TLAST_CHECK_EN
    logic err_q;
    always_ff @(posedge ap_clk) begin
        if (areset) err_q <= 1'b0;
        else if (state_q == IDLE && ctrl_start) err_q <= 1'b0;
        else if (s_hs && s_axis_tlast != last_in) err_q <= 1'b1;
    end
    assign err_tlast = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign err_tlast = 1'b0;
`endif
endmodule
